// File: rtl/ex_stage_tracker_if.sv
// Bundle of all EX-tracker signals except clk/rst. Slave is the tracker, master is its environment.
// EX_STAGE_TRACKER_RVALID_EN adds data_rvalid_i and out_mem_rvalid_o.
interface ex_stage_tracker_if #(
    parameter int REC_WIDTH   = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int CNT_WIDTH   = 32,
    parameter int QUEUE_DEPTH = 4
);
    logic [CNT_WIDTH-1:0]           counter_i;
    logic                           in_valid_i;
    logic                           in_ready_o;
    logic [REC_WIDTH-1:0]           in_rec_i;
    logic                           in_pass_i;
    logic                           ex_ready_i;
    logic                           data_req_i;
    logic [ADDR_WIDTH-1:0]          data_addr_i;
    logic                           data_gnt_i;
    logic                           out_valid_o;
    logic                           out_ready_i;
    logic [REC_WIDTH-1:0]           out_rec_o;
    logic                           out_pass_o;
    logic                           out_mem_o;
    logic [ADDR_WIDTH-1:0]          out_mem_addr_o;
    logic [CNT_WIDTH-1:0]           out_ex_start_o;
    logic [CNT_WIDTH-1:0]           out_ex_end_o;
    logic [CNT_WIDTH-1:0]           out_mem_req_o;
    logic [CNT_WIDTH-1:0]           out_mem_gnt_o;
    logic [CNT_WIDTH-1:0]           out_ex_cycles_o;
    logic                           overflow_o;
    logic [$clog2(QUEUE_DEPTH):0]   fill_o;
`ifdef EX_STAGE_TRACKER_RVALID_EN
    logic                           data_rvalid_i;
    logic [CNT_WIDTH-1:0]           out_mem_rvalid_o;
`endif

    modport slave (
        input  counter_i, in_valid_i, in_rec_i, in_pass_i, ex_ready_i,
               data_req_i, data_addr_i, data_gnt_i, out_ready_i,
`ifdef EX_STAGE_TRACKER_RVALID_EN
        input  data_rvalid_i,
        output out_mem_rvalid_o,
`endif
        output in_ready_o, out_valid_o, out_rec_o, out_pass_o, out_mem_o,
               out_mem_addr_o, out_ex_start_o, out_ex_end_o, out_mem_req_o,
               out_mem_gnt_o, out_ex_cycles_o, overflow_o, fill_o
    );

    modport master (
        output counter_i, in_valid_i, in_rec_i, in_pass_i, ex_ready_i,
               data_req_i, data_addr_i, data_gnt_i, out_ready_i,
`ifdef EX_STAGE_TRACKER_RVALID_EN
        output data_rvalid_i,
        input  out_mem_rvalid_o,
`endif
        input  in_ready_o, out_valid_o, out_rec_o, out_pass_o, out_mem_o,
               out_mem_addr_o, out_ex_start_o, out_ex_end_o, out_mem_req_o,
               out_mem_gnt_o, out_ex_cycles_o, overflow_o, fill_o
    );
endinterface

// File: rtl/ex_stage_tracker.sv
// EX-stage trace tracker: record FIFO plus an FSM timestamping execute and data-memory handshake.
// Optional EX_STAGE_TRACKER_RVALID_EN extends the memory phase until the read-valid response.
module ex_stage_tracker #(
    parameter int REC_WIDTH   = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int CNT_WIDTH   = 32,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    ex_stage_tracker_if.slave  bus
);
    localparam int IDX_W = $clog2(QUEUE_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVE,
        S_WAIT_GNT,
`ifdef EX_STAGE_TRACKER_RVALID_EN
        S_WAIT_RVALID,
`endif
        S_EMIT
    } state_e;

    logic [REC_WIDTH-1:0]  rec_mem  [QUEUE_DEPTH];
    logic                  pass_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fill;
    logic                  full, empty, push, pop;

    state_e                state_q, state_d;
    logic                  overflow_q, overflow_d;
    logic [REC_WIDTH-1:0]  rec_q, rec_d;
    logic                  pass_q, pass_d, mem_q, mem_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]  ex_start_q, ex_start_d, ex_end_q, ex_end_d;
    logic [CNT_WIDTH-1:0]  mem_req_q, mem_req_d, mem_gnt_q, mem_gnt_d;
`ifdef EX_STAGE_TRACKER_RVALID_EN
    logic [CNT_WIDTH-1:0]  mem_rvalid_q, mem_rvalid_d;
`endif

    // in_ready depends only on the pointer flops, never on this cycle's pop.
    assign fill  = wr_ptr_q - rd_ptr_q;
    assign full  = (fill == PTR_W'(QUEUE_DEPTH));
    assign empty = (fill == '0);
    assign push  = bus.in_valid_i && !full;

    // NOTE: storage arrays are not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            rec_mem[wr_ptr_q[IDX_W-1:0]]  <= bus.in_rec_i;
            pass_mem[wr_ptr_q[IDX_W-1:0]] <= bus.in_pass_i;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default here so no path can infer a latch.
        state_d    = state_q;
        pop        = 1'b0;
        rec_d      = rec_q;
        pass_d     = pass_q;
        mem_d      = mem_q;
        addr_d     = addr_q;
        ex_start_d = ex_start_q;
        ex_end_d   = ex_end_q;
        mem_req_d  = mem_req_q;
        mem_gnt_d  = mem_gnt_q;
`ifdef EX_STAGE_TRACKER_RVALID_EN
        mem_rvalid_d = mem_rvalid_q;
`endif
        overflow_d = overflow_q | (bus.in_valid_i && full);

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    rec_d      = rec_mem[rd_ptr_q[IDX_W-1:0]];
                    pass_d     = pass_mem[rd_ptr_q[IDX_W-1:0]];
                    mem_d      = 1'b0;
                    addr_d     = '0;
                    ex_start_d = '0;
                    ex_end_d   = '0;
                    mem_req_d  = '0;
                    mem_gnt_d  = '0;
`ifdef EX_STAGE_TRACKER_RVALID_EN
                    mem_rvalid_d = '0;
`endif
                    if (pass_mem[rd_ptr_q[IDX_W-1:0]]) begin
                        state_d = S_EMIT;
                    end else begin
                        ex_start_d = bus.counter_i;
                        if (bus.ex_ready_i) begin
                            ex_end_d = bus.counter_i;
                            state_d  = S_EMIT;
                        end else if (bus.data_req_i) begin
                            mem_d     = 1'b1;
                            addr_d    = bus.data_addr_i;
                            mem_req_d = bus.counter_i;
                            state_d   = S_WAIT_GNT;
                        end else begin
                            state_d = S_ACTIVE;
                        end
                    end
                end
            end
            S_ACTIVE: begin
                if (bus.ex_ready_i) begin
                    ex_end_d = bus.counter_i;
                    state_d  = S_EMIT;
                end else if (bus.data_req_i) begin
                    mem_d     = 1'b1;
                    addr_d    = bus.data_addr_i;
                    mem_req_d = bus.counter_i;
                    state_d   = S_WAIT_GNT;
                end
            end
            S_WAIT_GNT: begin
                if (bus.data_gnt_i) begin
                    mem_gnt_d = bus.counter_i;
`ifdef EX_STAGE_TRACKER_RVALID_EN
                    state_d   = S_WAIT_RVALID;
`else
                    ex_end_d  = bus.counter_i;
                    state_d   = S_EMIT;
`endif
                end
            end
`ifdef EX_STAGE_TRACKER_RVALID_EN
            S_WAIT_RVALID: begin
                if (bus.data_rvalid_i) begin
                    mem_rvalid_d = bus.counter_i;
                    ex_end_d     = bus.counter_i;
                    state_d      = S_EMIT;
                end
            end
`endif
            S_EMIT: begin
                if (bus.out_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            rec_q      <= '0;
            pass_q     <= 1'b0;
            mem_q      <= 1'b0;
            addr_q     <= '0;
            ex_start_q <= '0;
            ex_end_q   <= '0;
            mem_req_q  <= '0;
            mem_gnt_q  <= '0;
`ifdef EX_STAGE_TRACKER_RVALID_EN
            mem_rvalid_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            rec_q      <= rec_d;
            pass_q     <= pass_d;
            mem_q      <= mem_d;
            addr_q     <= addr_d;
            ex_start_q <= ex_start_d;
            ex_end_q   <= ex_end_d;
            mem_req_q  <= mem_req_d;
            mem_gnt_q  <= mem_gnt_d;
`ifdef EX_STAGE_TRACKER_RVALID_EN
            mem_rvalid_q <= mem_rvalid_d;
`endif
        end
    end

    assign bus.in_ready_o      = !full;
    assign bus.fill_o          = fill;
    assign bus.overflow_o      = overflow_q;
    assign bus.out_valid_o     = (state_q == S_EMIT);
    assign bus.out_rec_o       = rec_q;
    assign bus.out_pass_o      = pass_q;
    assign bus.out_mem_o       = mem_q;
    assign bus.out_mem_addr_o  = addr_q;
    assign bus.out_ex_start_o  = ex_start_q;
    assign bus.out_ex_end_o    = ex_end_q;
    assign bus.out_mem_req_o   = mem_req_q;
    assign bus.out_mem_gnt_o   = mem_gnt_q;
    // Modulo subtraction keeps the duration correct across a counter wrap.
    assign bus.out_ex_cycles_o = ex_end_q - ex_start_q;
`ifdef EX_STAGE_TRACKER_RVALID_EN
    assign bus.out_mem_rvalid_o = mem_rvalid_q;
`endif
endmodule
